// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART transmit path
// between NUM_REQ byte-stream requesters. Bytes are issued one at a time via
// trans_en/data_out and sequenced from tx_busy. A UART that never starts a
// frame is retried a bounded number of times, then the byte is dropped.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 64,
  parameter int MAX_RETRY    = 2
) (
  input  logic                       input_clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       trans_en,
  output logic [7:0]                 data_out,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       pkt_done,
  output logic                       tx_err,
  input  logic                       err_clr
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    PULSE,
    WAIT_BUSY,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] next_grant;
  logic          any_valid;
  logic          handshake;
  logic          timeout_hit;
  logic          drop;
  logic          byte_done;
  logic          last_q;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] retry_cnt;

  // Round-robin search: first valid requester strictly above the last owner
  always_comb begin
    int unsigned idx;
    idx        = 0;
    next_grant = last_grant;
    any_valid  = 1'b0;
    for (int unsigned i = 1; i <= 32'(NUM_REQ); i++) begin
      idx = (32'(last_grant) + i) % 32'(NUM_REQ);
      if (!any_valid && req_valid[GW'(idx)]) begin
        any_valid  = 1'b1;
        next_grant = GW'(idx);
      end
    end
  end

  // Handshake and byte-completion decode; req_ready must be same-cycle with
  // valid so it is decoded from the registered state rather than registered
  always_comb begin
    handshake   = (state == ACCEPT) && req_valid[grant_id] && !tx_busy;
    timeout_hit = (state == WAIT_BUSY) && !tx_busy &&
                  (to_cnt == TW'(BUSY_TIMEOUT - 1));
    drop        = timeout_hit && (retry_cnt == RW'(MAX_RETRY));
    byte_done   = ((state == WAIT_IDLE) && !tx_busy) || drop;
    req_ready   = '0;
    if (handshake) req_ready[grant_id] = 1'b1;
  end

  // Main sequencer: grant, accept, pulse, wait for frame start/end, retry
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= GW'(NUM_REQ - 1);
      grant_id     <= '0;
      grant_active <= 1'b0;
      data_out     <= '0;
      last_q       <= 1'b0;
      trans_en     <= 1'b0;
      pkt_done     <= 1'b0;
      tx_err       <= 1'b0;
      to_cnt       <= '0;
      retry_cnt    <= '0;
    end else begin
      trans_en <= 1'b0;
      pkt_done <= 1'b0;
      if (err_clr) tx_err <= 1'b0;
      if (drop)    tx_err <= 1'b1;

      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id     <= next_grant;
            grant_active <= 1'b1;
            state        <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (handshake) begin
            data_out <= req_data[{grant_id, 3'b000} +: 8];
            last_q   <= req_last[grant_id];
            trans_en <= 1'b1;
            state    <= PULSE;
          end
        end
        PULSE: begin
          to_cnt <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            retry_cnt <= '0;
            state     <= WAIT_IDLE;
          end else if (timeout_hit) begin
            if (!drop) begin
              retry_cnt <= retry_cnt + 1'b1;
              trans_en  <= 1'b1;
              state     <= PULSE;
            end else begin
              retry_cnt <= '0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_IDLE: ;
        default: state <= IDLE;
      endcase

      // A dropped byte leaves through the same exit as a completed frame
      if (byte_done) begin
        if (last_q) begin
          pkt_done     <= 1'b1;
          last_grant   <= grant_id;
          grant_active <= 1'b0;
          state        <= IDLE;
        end else begin
          state <= ACCEPT;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-stream sources, a simple UART
// busy model, and event monitors feeding per-scenario checks.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;

  logic               input_clk = 1'b0;
  logic               reset     = 1'b1;
  logic [NUM_REQ-1:0] req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic               trans_en;
  logic [7:0]         data_out;
  logic               tx_busy;
  logic [1:0]         grant_id;
  logic               grant_active;
  logic               pkt_done;
  logic               tx_err;
  logic               err_clr = 1'b0;

  int checks = 0;
  int passed = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(64), .MAX_RETRY(2)) dut (
    .input_clk   (input_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .trans_en    (trans_en),
    .data_out    (data_out),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .grant_active(grant_active),
    .pkt_done    (pkt_done),
    .tx_err      (tx_err),
    .err_clr     (err_clr)
  );

  always #5 input_clk = ~input_clk;

  // UART model: busy one cycle after trans_en, for 20 cycles
  int unsigned rem = 0;
  logic uart_on    = 1'b1;
  logic force_busy = 1'b0;
  always @(posedge input_clk or negedge reset) begin
    if (!reset)                  rem <= 0;
    else if (trans_en && uart_on) rem <= 20;
    else if (rem != 0)           rem <= rem - 1;
  end
  assign tx_busy = (rem != 0) || force_busy;

  // Byte sources: each requester presents its queue head while non-empty
  logic [7:0] src_data [NUM_REQ][16];
  logic       src_last [NUM_REQ][16];
  int         src_len  [NUM_REQ] = '{default: 0};
  int         src_ptr  [NUM_REQ] = '{default: 0};

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (src_ptr[r] < src_len[r]) begin
        req_valid[r]       = 1'b1;
        req_data[8*r +: 8] = src_data[r][src_ptr[r]];
        req_last[r]        = src_last[r][src_ptr[r]];
      end
    end
  end

  always @(posedge input_clk)
    for (int r = 0; r < NUM_REQ; r++)
      if (req_valid[r] && req_ready[r]) src_ptr[r] <= src_ptr[r] + 1;

  // Event monitors sampled on the falling edge
  int         cyc = 0, te_cnt = 0, acc_cnt = 0, pd_cnt = 0, rdy_busy_cnt = 0;
  logic [7:0] te_data [64];
  logic [1:0] te_gid  [64];
  int         te_cyc  [64];
  int         acc_req [64];
  int         acc_cyc [64];

  always @(negedge input_clk) begin
    cyc++;
    if (trans_en && te_cnt < 64) begin
      te_data[te_cnt] = data_out;
      te_gid[te_cnt]  = grant_id;
      te_cyc[te_cnt]  = cyc;
      te_cnt++;
    end
    for (int r = 0; r < NUM_REQ; r++)
      if (req_valid[r] && req_ready[r] && acc_cnt < 64) begin
        acc_req[acc_cnt] = r;
        acc_cyc[acc_cnt] = cyc;
        acc_cnt++;
      end
    if (pkt_done) pd_cnt++;
    if (req_ready != '0 && tx_busy) rdy_busy_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge input_clk);
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    src_data[r][src_len[r]] = d;
    src_last[r][src_len[r]] = l;
    src_len[r]++;
  endtask

  task automatic wait_pd(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (pd_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    @(posedge input_clk); #1;
    checks++;
    if ({trans_en, pkt_done, grant_active, tx_err} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {trans_en, pkt_done, grant_active, tx_err});
    else passed++;
    checks++;
    if (data_out !== 8'h00) $display("FAIL reset_data: got %h expected 00", data_out);
    else passed++;
    checks++;
    if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d expected 0", grant_id);
    else passed++;
    checks++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready);
    else passed++;
    cycles(1);
    reset = 1'b1;
  endtask

  task automatic test_single();
    int b_te, b_pd, bad;
    bit ok;
    logic [7:0] ed [3];
    ed = '{8'hA5, 8'h5A, 8'hFF};
    b_te = te_cnt; b_pd = pd_cnt; bad = 0;
    push(0, 8'hA5, 1'b0); push(0, 8'h5A, 1'b0); push(0, 8'hFF, 1'b1);
    wait_pd(b_pd + 1, ok);
    cycles(10);
    checks++;
    if (!ok) $display("FAIL single_timeout: got no pkt_done expected 1");
    else passed++;
    checks++;
    if (te_cnt - b_te !== 3) $display("FAIL single_pulses: got %0d expected 3", te_cnt - b_te);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (te_data[b_te+i] !== ed[i])
        $display("FAIL single_data%0d: got %h expected %h", i, te_data[b_te+i], ed[i]);
      else passed++;
    end
    for (int i = 0; i < 3; i++) if (te_gid[b_te+i] !== 2'd0) bad++;
    checks++;
    if (bad !== 0) $display("FAIL single_grant: got %0d non-zero grants expected 0", bad);
    else passed++;
    checks++;
    if (pd_cnt - b_pd !== 1) $display("FAIL single_pkt_done: got %0d expected 1", pd_cnt - b_pd);
    else passed++;
  endtask

  task automatic test_round_robin();
    int b_te, b_acc, b_pd;
    bit ok;
    logic [7:0] ed [8];
    int er [8];
    ed = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h12, 8'h13};
    er = '{0, 0, 1, 1, 2, 2, 0, 0};
    reset = 1'b0;
    b_te = te_cnt; b_acc = acc_cnt; b_pd = pd_cnt;
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1); push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
    push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
    push(2, 8'h30, 1'b0); push(2, 8'h31, 1'b1);
    cycles(2);
    reset = 1'b1;
    wait_pd(b_pd + 4, ok);
    checks++;
    if (!ok || te_cnt - b_te !== 8)
      $display("FAIL rr_count: got %0d pulses expected 8", te_cnt - b_te);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (te_data[b_te+i] !== ed[i] || acc_req[b_acc+i] !== er[i])
        $display("FAIL rr_order%0d: got req %0d data %h expected req %0d data %h",
                 i, acc_req[b_acc+i], te_data[b_te+i], er[i], ed[i]);
      else passed++;
    end
  endtask

  task automatic test_hold();
    int b_te, b_acc, b_pd;
    bit ok;
    logic [7:0] ed [4];
    int er [4];
    ed = '{8'h40, 8'h41, 8'h50, 8'h51};
    er = '{3, 3, 1, 1};
    b_te = te_cnt; b_acc = acc_cnt; b_pd = pd_cnt;
    push(3, 8'h40, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (acc_cnt > b_acc) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
    push(1, 8'h50, 1'b0); push(1, 8'h51, 1'b1);
    cycles(50);
    checks++;
    if (!ok || grant_id !== 2'd3 || grant_active !== 1'b1)
      $display("FAIL hold_grant: got id %0d active %b expected id 3 active 1", grant_id, grant_active);
    else passed++;
    checks++;
    if (acc_cnt - b_acc !== 1) $display("FAIL hold_no_ready: got %0d accepts expected 1", acc_cnt - b_acc);
    else passed++;
    push(3, 8'h41, 1'b1);
    wait_pd(b_pd + 2, ok);
    checks++;
    if (!ok) $display("FAIL hold_timeout: got %0d pkt_done expected 2", pd_cnt - b_pd);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (te_data[b_te+i] !== ed[i] || acc_req[b_acc+i] !== er[i])
        $display("FAIL hold_order%0d: got req %0d data %h expected req %0d data %h",
                 i, acc_req[b_acc+i], te_data[b_te+i], er[i], ed[i]);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    int b_te, b_pd;
    bit ok;
    b_te = te_cnt; b_pd = pd_cnt;
    uart_on = 1'b0;
    push(0, 8'h60, 1'b0); push(0, 8'h61, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (tx_err === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
    uart_on = 1'b1;
    checks++;
    if (!ok || te_cnt - b_te !== 3)
      $display("FAIL timeout_pulses: got %0d pulses err %b expected 3 err 1", te_cnt - b_te, tx_err);
    else passed++;
    checks++;
    if (te_data[b_te] !== 8'h60 || te_data[b_te+1] !== 8'h60 || te_data[b_te+2] !== 8'h60)
      $display("FAIL timeout_data: got %h %h %h expected 60 60 60",
               te_data[b_te], te_data[b_te+1], te_data[b_te+2]);
    else passed++;
    checks++;
    if (te_cyc[b_te+1] - te_cyc[b_te] !== 65 || te_cyc[b_te+2] - te_cyc[b_te+1] !== 65)
      $display("FAIL timeout_spacing: got %0d %0d expected 65 65",
               te_cyc[b_te+1] - te_cyc[b_te], te_cyc[b_te+2] - te_cyc[b_te+1]);
    else passed++;
    wait_pd(b_pd + 1, ok);
    checks++;
    if (!ok || te_cnt - b_te !== 4 || te_data[b_te+3] !== 8'h61)
      $display("FAIL timeout_next: got %0d pulses last %h expected 4 pulses last 61",
               te_cnt - b_te, te_data[b_te+3]);
    else passed++;
    checks++;
    if (tx_err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", tx_err);
    else passed++;
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    checks++;
    if (tx_err !== 1'b0) $display("FAIL err_clr: got %b expected 0", tx_err);
    else passed++;
  endtask

  task automatic test_async_reset();
    int b_te, b_acc, b_pd;
    bit ok;
    b_te = te_cnt; b_pd = pd_cnt;
    push(0, 8'h70, 1'b0); push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (te_cnt >= b_te + 2) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
    cycles(5);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (!ok || data_out !== 8'h00)
      $display("FAIL async_data: got %h expected 00", data_out);
    else passed++;
    checks++;
    if ({trans_en, grant_id, grant_active, pkt_done, tx_err, req_ready} !== 10'b0)
      $display("FAIL async_outputs: got %b expected 0",
               {trans_en, grant_id, grant_active, pkt_done, tx_err, req_ready});
    else passed++;
    b_te = te_cnt; b_acc = acc_cnt; b_pd = pd_cnt;
    push(1, 8'h80, 1'b1);
    @(posedge input_clk); #1;
    reset = 1'b1;
    wait_pd(b_pd + 2, ok);
    checks++;
    if (!ok || acc_req[b_acc] !== 0 || te_data[b_te] !== 8'h72)
      $display("FAIL async_rearb: got req %0d data %h expected req 0 data 72",
               acc_req[b_acc], te_data[b_te]);
    else passed++;
    checks++;
    if (acc_req[b_acc+1] !== 1 || te_data[b_te+1] !== 8'h80)
      $display("FAIL async_second: got req %0d data %h expected req 1 data 80",
               acc_req[b_acc+1], te_data[b_te+1]);
    else passed++;
  endtask

  task automatic test_busy_first();
    int b_te, b_acc, b_pd, rel;
    bit ok;
    force_busy = 1'b1;
    cycles(10);
    b_te = te_cnt; b_acc = acc_cnt; b_pd = pd_cnt;
    push(2, 8'h90, 1'b1);
    cycles(20);
    checks++;
    if (grant_active !== 1'b1 || grant_id !== 2'd2)
      $display("FAIL busy_grant: got id %0d active %b expected id 2 active 1", grant_id, grant_active);
    else passed++;
    checks++;
    if (acc_cnt !== b_acc || te_cnt !== b_te)
      $display("FAIL busy_blocked: got %0d accepts %0d pulses expected 0 0", acc_cnt - b_acc, te_cnt - b_te);
    else passed++;
    rel = cyc;
    force_busy = 1'b0;
    wait_pd(b_pd + 1, ok);
    checks++;
    if (!ok || acc_req[b_acc] !== 2 || acc_cyc[b_acc] <= rel || te_data[b_te] !== 8'h90)
      $display("FAIL busy_release: got req %0d at %0d data %h expected req 2 after %0d data 90",
               acc_req[b_acc], acc_cyc[b_acc], te_data[b_te], rel);
    else passed++;
    checks++;
    if (rdy_busy_cnt !== 0) $display("FAIL ready_while_busy: got %0d expected 0", rdy_busy_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_timeout();
    test_async_reset();
    test_busy_first();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path of the UART communication block between NUM_REQ byte-stream requesters, e.g. the capture-buffer dump engine, the status reporter and command echo.
- Arbitrates round-robin at packet granularity.
- Feeds one byte at a time into the UART's trans_en/data_out pair and sequences it from tx_busy.
- Detects a UART that never starts a frame and recovers with bounded retries.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 64, input_clk cycles to wait for tx_busy to rise after a trans_en pulse.
- MAX_RETRY, 2, trans_en re-pulses allowed after a timeout before the byte is dropped.

Ports:
- input_clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a packet.
- req_ready  out  NUM_REQ  one-hot, one-cycle pulse; the byte is accepted when valid and ready are both high.
- trans_en  out  1  one-cycle start pulse to the UART.
- data_out  out  8  byte to the UART; held stable from the pulse until the frame ends.
- tx_busy  in  1  UART busy indication.
- grant_id  out  $clog2(NUM_REQ)  index of the requester that owns the UART; valid while grant_active.
- grant_active  out  1  a packet is in progress.
- pkt_done  out  1  one-cycle pulse when the last byte of a packet completes or is dropped.
- tx_err  out  1  sticky flag: a byte was dropped after retries were exhausted.
- err_clr  in  1  clears tx_err.

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - All outputs 0: req_ready, trans_en, data_out, grant_id, grant_active, pkt_done, tx_err.
  - Round-robin pointer last_grant = NUM_REQ-1.
  - Retry and timeout counters 0.
- FSM states: IDLE, ACCEPT, PULSE, WAIT_BUSY, WAIT_IDLE.
- IDLE:
  - If any req_valid, grant the first valid index searching upward from last_grant+1 (mod NUM_REQ).
  - Set grant_id and grant_active=1, go to ACCEPT.
  - Arbitration takes 1 cycle.
- ACCEPT:
  - Waits while req_valid[grant_id]=0 or tx_busy=1. The grant stays locked; other requesters are ignored.
  - When req_valid[grant_id]=1 and tx_busy=0: pulse req_ready[grant_id] for exactly this cycle, register req_data into data_out, register req_last, then go to PULSE.
- PULSE:
  - trans_en=1 for exactly one cycle.
  - Clear the timeout counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_IDLE and clear the retry counter.
  - Otherwise increment the timeout counter. When it reaches BUSY_TIMEOUT:
    - If retry < MAX_RETRY: retry++, go to PULSE (same data_out).
    - Else: set tx_err, clear retry, and treat the byte as complete (same exit as WAIT_IDLE).
- WAIT_IDLE:
  - On tx_busy=0, the byte is complete.
  - If the registered last flag is set: pulse pkt_done, set last_grant=grant_id, grant_active=0, go to IDLE.
  - Otherwise go to ACCEPT with the same grant.
- data_out changes only in ACCEPT on a handshake. It never changes during PULSE, WAIT_BUSY or WAIT_IDLE.
- Minimum byte-to-byte overhead is 3 cycles plus the UART frame time. At most one byte is outstanding at any time.
- tx_busy=1 seen in IDLE or ACCEPT (for example, still busy from a previous user) delays acceptance; it is not an error.
- err_clr:
  - err_clr=1 clears tx_err on the next edge.
  - If a drop event occurs in the same cycle, set wins.
- A requester may drop req_valid mid-packet; the grant stays held indefinitely until it sends req_last. No preemption.
- req_last on a single-byte packet is legal; pkt_done follows that byte.
- If a requester's valid deasserts in the same cycle as its grant in IDLE, ACCEPT simply waits.

Test Plan:
- Single requester 0 sends 3 bytes 0xA5, 0x5A, 0xFF with last on 0xFF; UART model raises tx_busy 1 cycle after trans_en and holds it 20 cycles.
  - Required: 3 trans_en pulses with data_out = A5, 5A, FF.
  - Required: exactly one pkt_done; grant_id=0 throughout.
- Requesters 0, 1, 2 all hold 2-byte packets valid from reset.
  - Required: grant order 0, 1, 2, then back to 0 if 0 re-requests.
  - Required: no interleaving of bytes between packets.
- Requester 3 granted mid-packet drops valid for 50 cycles while requester 1 is valid.
  - Required: grant stays 3, no req_ready to 1, requester 3's packet completes first.
- UART model never raises tx_busy (BUSY_TIMEOUT=64, MAX_RETRY=2).
  - Required: 3 trans_en pulses 65 cycles apart, then tx_err=1 and the byte is dropped.
  - Required: the next byte proceeds; err_clr returns tx_err to 0.
- Assert reset low during WAIT_IDLE of byte 2.
  - Required: all outputs 0 immediately (async).
  - Required: after release, IDLE re-arbitrates starting from index 0.
- tx_busy held high for 30 cycles before any request, then requester 2 valid.
  - Required: req_ready[2] only after tx_busy falls; no trans_en while busy.
